// File: rtl/shift_sequencer.sv
// shift_sequencer: command sequencer driving a downstream univshift (M/parin/lin/rin).
// Define SHSEQ_ROTATE_EN to make SHL/SHR with fill=1 rotate using q_in.
module shift_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    input  logic       cmd_fill,
    input  logic [3:0] q_in,
    output logic [1:0] M,
    output logic [3:0] parin,
    output logic       lin,
    output logic       rin,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [2:0] cnt;
    logic lin_r, rin_r;
    assign cmd_ready = state == IDLE;
    assign busy = state != IDLE;
`ifdef SHSEQ_ROTATE_EN
    logic [1:0] op;
    logic fill;
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            op <= 2'b00;
            fill <= 1'b0;
        end else if (state == IDLE && cmd_valid) begin
            op <= cmd_op;
            fill <= cmd_fill;
        end
    // rotation closes the loop through the downstream register's current Q
    assign lin = (state == RUN && fill && op == 2'b10) ? q_in[0] : lin_r;
    assign rin = (state == RUN && fill && op == 2'b01) ? q_in[3] : rin_r;
`else
    logic unused_q;
    assign unused_q = ^q_in;
    assign lin = lin_r;
    assign rin = rin_r;
`endif
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state <= IDLE;
            cnt <= 3'd0;
            M <= 2'b00;
            parin <= 4'b0000;
            lin_r <= 1'b0;
            rin_r <= 1'b0;
            done <= 1'b0;
        end else
            case (state)
                IDLE: if (cmd_valid) begin
                    if (cmd_op == 2'b00) begin
                        state <= RUN;
                        cnt <= 3'd1;
                        M <= 2'b11;
                        parin <= cmd_data;
                    end else if (cmd_cnt == 3'd0) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else begin
                        state <= RUN;
                        cnt <= cmd_cnt;
                        M <= cmd_op == 2'b11 ? 2'b00 : cmd_op;
                        lin_r <= cmd_op == 2'b10 && cmd_fill;
                        rin_r <= cmd_op == 2'b01 && cmd_fill;
                    end
                end
                RUN: begin
                    cnt <= cnt != 3'd0 ? cnt - 3'd1 : 3'd0;
                    if (cnt <= 3'd1) begin
                        state <= DONE;
                        M <= 2'b00;
                        parin <= 4'b0000;
                        lin_r <= 1'b0;
                        rin_r <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
            endcase
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed test of shift_sequencer against a cycle schedule model
// and a behavioural univshift register closing the q_in loop.
module tb_shift_sequencer;
    logic clk = 0, clr = 0, cmd_valid = 0, cmd_fill = 0;
    logic [1:0] cmd_op = 0;
    logic [2:0] cmd_cnt = 0;
    logic [3:0] cmd_data = 0;
    logic [3:0] q = 0;
    logic cmd_ready, lin, rin, busy, done;
    logic [1:0] m;
    logic [3:0] parin;
    int errors = 0, checks = 0;
`ifdef SHSEQ_ROTATE_EN
    localparam bit ROT = 1;
`else
    localparam bit ROT = 0;
`endif

    shift_sequencer dut (.clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .q_in(q), .M(m), .parin(parin), .lin(lin), .rin(rin), .busy(busy), .done(done));

    always #5 clk = ~clk;

    // downstream univshift
    always @(posedge clk)
        case (m)
            2'b11: q <= parin;
            2'b01: q <= {q[2:0], rin};
            2'b10: q <= {lin, q[3:1]};
            default: q <= q;
        endcase

    typedef struct {int st; logic [1:0] m; logic [3:0] p; logic l, r, rl, rr;} ent_t;
    localparam ent_t IDLE_E = '{0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ent_t DONE_E = '{2, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    ent_t sched[$];
    ent_t cur = IDLE_E;

    // expected outputs for each cycle: an accepted command expands into its whole schedule
    always @(posedge clk or negedge clr)
        if (!clr) begin
            sched.delete();
            cur = IDLE_E;
        end else begin
            if (cur.st == 0 && cmd_valid) begin
                if (cmd_op == 2'b00)
                    sched.push_back('{1, 2'b11, cmd_data, 1'b0, 1'b0, 1'b0, 1'b0});
                else
                    for (int i = 0; i < int'(cmd_cnt); i++)
                        sched.push_back('{1, cmd_op == 2'b01 ? 2'b01 : cmd_op == 2'b10 ? 2'b10 : 2'b00, 4'b0000,
                            cmd_op == 2'b10 && cmd_fill, cmd_op == 2'b01 && cmd_fill,
                            ROT && cmd_op == 2'b10 && cmd_fill, ROT && cmd_op == 2'b01 && cmd_fill});
                sched.push_back(DONE_E);
            end
            cur = sched.size() > 0 ? sched.pop_front() : IDLE_E;
        end

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk)
        if (clr) begin
            chk("m", 8'(m), 8'(cur.m));
            chk("parin", 8'(parin), 8'(cur.p));
            chk("lin", 8'(lin), 8'(cur.rl ? q[0] : cur.l));
            chk("rin", 8'(rin), 8'(cur.rr ? q[3] : cur.r));
            chk("done", 8'(done), 8'(cur.st == 2));
            chk("busy", 8'(busy), 8'(cur.st != 0));
            chk("ready", 8'(cmd_ready), 8'(cur.st == 0));
        end

    task automatic cmd(input logic [1:0] op, input logic [2:0] n, input logic [3:0] d, input logic f);
        @(posedge clk);
        #1 cmd_valid = 1; cmd_op = op; cmd_cnt = n; cmd_data = d; cmd_fill = f;
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic nx;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_m", 8'(m), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_done", 8'(done), 8'h0);
        #10 clr = 1;
        nx; chk("rst_ready", 8'(cmd_ready), 8'h1);
        cmd(2'b00, 3'd5, 4'b1011, 1'b0);
        nx; chk("load_m", 8'(m), 8'h3); chk("load_parin", 8'(parin), 8'hb);
        nx; chk("load_q", 8'(q), 8'hb); chk("load_done", 8'(done), 8'h1);
        nx; chk("load_ready", 8'(cmd_ready), 8'h1);
        cmd(2'b01, 3'd2, 4'b0000, 1'b1);
        nx; chk("shl_m1", 8'(m), 8'h1);
        nx; chk("shl_m2", 8'(m), 8'h1); chk("shl_q1", 8'(q), 8'h7);
        nx; chk("shl_q2", 8'(q), 8'hf); chk("shl_done", 8'(done), 8'h1);
        cmd(2'b00, 3'd0, 4'b1011, 1'b0);
        nx; nx;
        cmd(2'b10, 3'd3, 4'b0000, 1'b0);
        nx; chk("shr_m", 8'(m), 8'h2);
        nx; chk("shr_q1", 8'(q), 8'h5);
        cmd_valid = 1; cmd_op = 2'b00; cmd_data = 4'b0000;
        nx; chk("shr_q2", 8'(q), 8'h2);
        cmd_valid = 0;
        nx; chk("shr_q3", 8'(q), 8'h1); chk("shr_done", 8'(done), 8'h1);
        nx; chk("shr_ready", 8'(cmd_ready), 8'h1); chk("shr_ignored", 8'(m), 8'h0);
        nx; chk("shr_idle", 8'(busy), 8'h0);
        cmd(2'b01, 3'd0, 4'b0000, 1'b1);
        nx; chk("cnt0_done", 8'(done), 8'h1); chk("cnt0_m", 8'(m), 8'h0);
        nx; chk("cnt0_q", 8'(q), 8'h1); chk("cnt0_ready", 8'(cmd_ready), 8'h1);
        cmd(2'b10, 3'd7, 4'b0000, 1'b1);
        nx; nx; chk("abort_busy", 8'(busy), 8'h1);
        @(posedge clk);
        #2 clr = 0;
        #1;
        chk("abort_m", 8'(m), 8'h0); chk("abort_lin", 8'(lin), 8'h0);
        chk("abort_rin", 8'(rin), 8'h0); chk("abort_parin", 8'(parin), 8'h0);
        chk("abort_done", 8'(done), 8'h0); chk("abort_busy0", 8'(busy), 8'h0);
        repeat (2) @(negedge clk);
        clr = 1;
        nx; chk("abort_ready", 8'(cmd_ready), 8'h1);
        for (int i = 0; i < 3; i++) begin
            nx; chk("abort_nodone", 8'(done), 8'h0);
        end
        cmd(2'b00, 3'd0, 4'b1011, 1'b0);
        nx; nx;
        cmd(2'b01, 3'd4, 4'b0000, 1'b1);
        nx;
`ifdef SHSEQ_ROTATE_EN
        nx; chk("rot_q1", 8'(q), 8'h7);
        nx; chk("rot_q2", 8'(q), 8'he);
        nx; chk("rot_q3", 8'(q), 8'hd);
        nx; chk("rot_q4", 8'(q), 8'hb); chk("rot_done", 8'(done), 8'h1);
`else
        nx; chk("fill_q1", 8'(q), 8'h7);
        nx; chk("fill_q2", 8'(q), 8'hf);
        nx; chk("fill_q3", 8'(q), 8'hf);
        nx; chk("fill_q4", 8'(q), 8'hf); chk("fill_done", 8'(done), 8'h1);
`endif
        nx; nx;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
